// File: rtl/key_event_encoder_pkg.sv
// Shared types for the key event encoder: FSM state encoding and the event record.
package keymix_pkg;

  localparam int MAX_CODE_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // rel stands in for "release", which is a reserved word
  typedef struct packed {
    logic                  rel;
    logic [MAX_CODE_W-1:0] code;
  } key_event_t;

endpackage

// File: rtl/key_event_encoder_if.sv
// Event stream from the encoder to its consumer: head-of-FIFO event plus valid/ready.
interface key_event_encoder_if #(
  parameter int CODE_W = 5
);

  logic [CODE_W-1:0] ev_code;
  logic              ev_release;
  logic              ev_valid;
  logic              ev_ready;

  modport master (output ev_code, ev_release, ev_valid, input ev_ready);
  modport slave  (input ev_code, ev_release, ev_valid, output ev_ready);

endinterface

// File: rtl/key_event_encoder_fifo.sv
// Small event FIFO; head entry is read straight from storage so the outputs never depend on ready_i.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;
  logic             isFull, isEmpty, doPop, doPush;

  // When full, a push only fits if the head leaves in the same cycle
  assign isFull  = (count_q == (PTR_W+1)'(DEPTH));
  assign isEmpty = (count_q == '0);
  assign doPop   = ready_i && !isEmpty;
  assign doPush  = push_i && (!isFull || doPop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && isFull && !doPop) overflow_q <= 1'b1;
    end
  end

  assign data_o     = mem_q[rdPtr_q];
  assign valid_o    = !isEmpty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/key_event_encoder.sv
// Debounced keypad encoder: synchronises raw key lines, tracks the highest pressed key,
// and queues press/release events for a valid/ready consumer.
module key_event_encoder #(
  parameter int NKEYS    = 20,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4,
  localparam int CODE_W  = $clog2(NKEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NKEYS-1:0]    in,
  key_event_encoder_if.master ev,
  output logic                held,
  output logic [CODE_W-1:0]   held_code,
  output logic                overflow
);

  import keymix_pkg::*;

  logic [NKEYS-1:0]  syncMeta_q, syncKeys_q;
  logic              anyKey;
  logic [CODE_W-1:0] keyCode;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] heldCode_q, heldCode_d;
  logic              sameKey, cntDone, pushEv, pushRel;
  logic [CODE_W:0]   headEv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncMeta_q <= '0;
      syncKeys_q <= '0;
    end else begin
      syncMeta_q <= in;
      syncKeys_q <= syncMeta_q;
    end
  end

  // Highest index wins when several keys are down
  always_comb begin
    anyKey  = |syncKeys_q;
    keyCode = '0;
    for (int i = 0; i < NKEYS; i++)
      if (syncKeys_q[i]) keyCode = CODE_W'(i);
  end

  assign sameKey = anyKey && (keyCode == heldCode_q);
  assign cntDone = (cnt_q == 8'(DEBOUNCE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      heldCode_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      heldCode_q <= heldCode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    heldCode_d = heldCode_q;
    case (state_q)
      IDLE: begin
        if (anyKey) begin
          heldCode_d = keyCode;
          cnt_d      = '0;
          state_d    = keymix_pkg::DEBOUNCE;
        end
      end
      keymix_pkg::DEBOUNCE: begin
        if (!sameKey)     state_d = IDLE;
        else if (cntDone) state_d = HELD;
        else              cnt_d   = cnt_q + 8'd1;
      end
      HELD: begin
        if (!sameKey) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A different key counts as the old one going away
        if (sameKey)      state_d = HELD;
        else if (cntDone) state_d = IDLE;
        else              cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    held    = (state_q == HELD);
    pushEv  = 1'b0;
    pushRel = (state_q == RELEASE);
    case (state_q)
      keymix_pkg::DEBOUNCE: pushEv = sameKey && cntDone;
      RELEASE:              pushEv = !sameKey && cntDone;
      default:              pushEv = 1'b0;
    endcase
  end

  assign held_code = heldCode_q;

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pushEv),
    .data_i     ({pushRel, heldCode_q}),
    .ready_i    (ev.ev_ready),
    .data_o     (headEv),
    .valid_o    (ev.ev_valid),
    .overflow_o (overflow)
  );

  assign ev.ev_release = headEv[CODE_W];
  assign ev.ev_code    = headEv[CODE_W-1:0];

endmodule

// File: tb/tb_key_event_encoder.sv
// Scoreboard bench for key_event_encoder: expected events are queued as keys are driven
// and matched against every event the consumer accepts.
module tb_key_event_encoder;

  import keymix_pkg::*;

  localparam int NK    = 20;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(NK);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] keys = '0;
  logic          held;
  logic [CW-1:0] heldCode;
  logic          overflow;

  int         total = 0;
  int         bad   = 0;
  key_event_t expQ[$];
  key_event_t monHead;

  key_event_encoder_if #(.CODE_W(CW)) evIf ();

  key_event_encoder #(
    .NKEYS    (NK),
    .DEBOUNCE (DEB),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (keys),
    .ev        (evIf),
    .held      (held),
    .held_code (heldCode),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectEvent(input logic rel, input int code);
    key_event_t e;
    e.rel  = rel;
    e.code = MAX_CODE_W'(code);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k, input int cycles);
    keys = k;
    tick(cycles);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  function automatic logic [NK-1:0] key(input int k);
    return NK'(1) << k;
  endfunction

  // Each accepted event must be the oldest one still expected
  always @(negedge clk) begin
    if (rst && evIf.ev_valid && evIf.ev_ready) begin
      checkOutput("sb_pending", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        monHead = expQ.pop_front();
        checkOutput("ev_code", evIf.ev_code, monHead.code);
        checkOutput("ev_release", evIf.ev_release, monHead.rel);
      end
    end
  end

  initial begin
    evIf.ev_ready = 1'b0;
    applyReset();
    checkOutput("rst_valid", evIf.ev_valid, 0);
    checkOutput("rst_held", held, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_code", evIf.ev_code, 0);
    checkOutput("rst_release", evIf.ev_release, 0);

    // Single key press/release with latency check
    evIf.ev_ready = 1'b1;
    expectEvent(1'b0, 5);
    applyStimulus(key(5), 6);
    checkOutput("lat_edge6", evIf.ev_valid, 0);
    tick(1);
    checkOutput("lat_edge7", evIf.ev_valid, 1);
    checkOutput("held_k5", held, 1);
    checkOutput("held_code5", heldCode, 5);
    tick(13);
    expectEvent(1'b1, 5);
    applyStimulus('0, 15);
    checkOutput("held_off5", held, 0);
    checkOutput("drained_single", expQ.size(), 0);

    // Short glitches never survive debounce
    for (int g = 0; g < 4; g++) begin
      applyStimulus(key(3), (g % 3) + 1);
      applyStimulus('0, 8);
      checkOutput("glitch_valid", evIf.ev_valid, 0);
      checkOutput("glitch_held", held, 0);
    end

    // Two keys: highest wins, then falling back to the lower key
    expectEvent(1'b0, 17);
    applyStimulus(key(2) | key(17), 15);
    checkOutput("held_code17", heldCode, 17);
    expectEvent(1'b1, 17);
    expectEvent(1'b0, 2);
    applyStimulus(key(2), 30);
    checkOutput("held_code2", heldCode, 2);
    checkOutput("held_k2", held, 1);
    expectEvent(1'b1, 2);
    applyStimulus('0, 15);
    checkOutput("drained_twokey", expQ.size(), 0);

    // Overflow with consumer stalled: six events offered, first four kept
    evIf.ev_ready = 1'b0;
    applyStimulus(key(1), 12);
    applyStimulus('0, 12);
    checkOutput("ovf_early", overflow, 0);
    applyStimulus(key(4), 12);
    applyStimulus('0, 12);
    applyStimulus(key(7), 12);
    applyStimulus('0, 12);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_valid", evIf.ev_valid, 1);
    expectEvent(1'b0, 1);
    expectEvent(1'b1, 1);
    expectEvent(1'b0, 4);
    expectEvent(1'b1, 4);
    evIf.ev_ready = 1'b1;
    tick(8);
    checkOutput("drained_ovf", expQ.size(), 0);
    checkOutput("ovf_sticky", overflow, 1);
    checkOutput("ovf_empty", evIf.ev_valid, 0);

    // Full FIFO: push coinciding with pop is accepted
    evIf.ev_ready = 1'b0;
    applyReset();
    checkOutput("ovf_cleared", overflow, 0);
    applyStimulus(key(6), 12);
    applyStimulus('0, 12);
    applyStimulus(key(8), 12);
    applyStimulus('0, 12);
    expectEvent(1'b0, 6);
    expectEvent(1'b1, 6);
    expectEvent(1'b0, 8);
    expectEvent(1'b1, 8);
    expectEvent(1'b0, 10);
    applyStimulus(key(10), 6);
    evIf.ev_ready = 1'b1;
    tick(1);
    evIf.ev_ready = 1'b0;
    checkOutput("fullpp_ovf", overflow, 0);
    checkOutput("fullpp_valid", evIf.ev_valid, 1);
    tick(5);
    applyStimulus('0, 12);
    checkOutput("fullpp_still_full", overflow, 1);
    evIf.ev_ready = 1'b1;
    tick(8);
    checkOutput("drained_fullpp", expQ.size(), 0);

    // Reset mid-debounce discards the pending press
    applyStimulus(key(9), 4);
    checkOutput("mid_deb_held", held, 0);
    keys = '0;
    applyReset();
    checkOutput("rst9_valid", evIf.ev_valid, 0);
    checkOutput("rst9_held", held, 0);
    checkOutput("rst9_overflow", overflow, 0);
    checkOutput("rst9_code", heldCode, 0);
    tick(10);
    checkOutput("rst9_quiet", evIf.ev_valid, 0);
    expectEvent(1'b0, 9);
    applyStimulus(key(9), 6);
    checkOutput("k9_edge6", evIf.ev_valid, 0);
    tick(1);
    checkOutput("k9_edge7", evIf.ev_valid, 1);
    tick(5);
    expectEvent(1'b1, 9);
    applyStimulus('0, 15);
    checkOutput("drained_k9", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter NKEYS, default 20, number of key inputs (2..64).
REQ-002 Parameter DEBOUNCE, default 4, cycles a key code must be stable before a press or release event is recognised (1..255).
REQ-003 Parameter DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-004 Derived constant CODE_W = $clog2(NKEYS), key code width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 in  input  NKEYS  raw asynchronous key lines; bit i high = key i pressed.
REQ-008 ev_code  output  CODE_W  key code of FIFO head event.
REQ-009 ev_release  output  1  head event type: 0 = press, 1 = release.
REQ-010 ev_valid  output  1  FIFO non-empty.
REQ-011 ev_ready  input  1  consumer accepts the head event when ev_valid && ev_ready.
REQ-012 held  output  1  high while FSM is in HELD.
REQ-013 held_code  output  CODE_W  captured code; meaningful only when held = 1.
REQ-014 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-015 in SHALL pass through a 2-flop synchroniser; all following logic uses the synchronised vector s.
REQ-016 Each cycle the encoder SHALL produce any = |s and code = index of the highest set bit of s (highest index wins), code = 0 when any = 0.
REQ-017 The FSM SHALL have states IDLE, DEBOUNCE, HELD and RELEASE, plus an 8-bit counter cnt.
REQ-018 IDLE: if any, capture code into held_code, cnt <= 0, go to DEBOUNCE; otherwise stay.
REQ-019 DEBOUNCE: if !any or code != held_code, go to IDLE with no event; else if cnt == DEBOUNCE-1, push press event {0, held_code} and go to HELD; else cnt <= cnt+1.
REQ-020 HELD: stay while any && code == held_code; otherwise cnt <= 0 and go to RELEASE.
REQ-021 RELEASE: if any && code == held_code, return to HELD with no event; else if cnt == DEBOUNCE-1, push release event {1, held_code} and go to IDLE; else cnt <= cnt+1.
REQ-022 A change to a different key while held SHALL be treated as release of the old key (release event) and then, from IDLE, a fresh press of the new key.
REQ-023 Latency: with a key stable from before rising edge 1, ev_valid SHALL rise after edge DEBOUNCE+3, which is 7 cycles for DEBOUNCE = 4, provided the FIFO is empty and not full.
REQ-024 FIFO SHALL be first-in first-out with DEPTH entries of CODE_W+1 bits; ev_code/ev_release SHALL be driven from the head register with no combinational path from ev_ready.
REQ-025 Pop occurs when ev_valid && ev_ready; a pop on empty SHALL be ignored.
REQ-026 A push when full without a simultaneous pop SHALL be dropped and SHALL set overflow; a push and pop in the same cycle when full SHALL both succeed.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished with an occupancy count of width $clog2(DEPTH)+1.

Reset
REQ-028 While rst = 0 at a rising edge: synchroniser = 0, state = IDLE, cnt = 0, held_code = 0, FIFO empty, overflow = 0.
REQ-029 Output values after reset: ev_valid = 0, held = 0, overflow = 0, ev_code = 0, ev_release = 0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL discard the pending event and all queued events; no release event SHALL be generated for a key still down when reset ends.

Structure
REQ-031 Package keymix_pkg SHALL hold the state enum (IDLE, DEBOUNCE, HELD, RELEASE) and the event struct {release, code}.
REQ-032 The FIFO SHALL be a separate sub-module, event_fifo, parametrised by DEPTH and width.

Verification
REQ-033 Press key 5 for 20 cycles then release, ev_ready = 1 -> press{0,5} is visible 7 cycles after the input rises, followed by release{1,5}, and no other events.
REQ-034 Send 2-cycle glitches on key 3 with DEBOUNCE = 4 -> no events, held stays 0.
REQ-035 Hold keys 2 and 17 together -> press{0,17}; release 17 while 2 stays down -> release{1,17}, then press{0,2}.
REQ-036 Hold ev_ready = 0 and generate 3 press/release pairs with DEPTH = 4 -> 4 events queued, overflow = 1, first 4 events read out in order.
REQ-037 Assert rst = 0 during DEBOUNCE for key 9 -> ev_valid = 0, state IDLE, overflow = 0 the cycle after reset; a new press of key 9 is then recognised normally.
REQ-038 Full FIFO with ev_ready = 1 while a new event is pushed -> push and pop both succeed, occupancy stays DEPTH, overflow unchanged.
